pocket_controller: RTL and testbench
====================================

POCKET_CONTROLLER -- requirements
Module: pocket_controller

Interface
REQ-001 Parameter NUM_BALLS, default 16, number of ball drawing-request inputs (2..16).
REQ-002 Parameter NUM_HOLES, default 6, number of hole drawing-request inputs (1..8).
REQ-003 Parameter OVERLAP_THRESH, default 64, per-frame overlap pixel count at which a ball is declared pocketed (1..127).
REQ-004 clk  input  1  system clock; all state changes on its rising edge.
REQ-005 resetN  input  1  asynchronous, active-low reset.
REQ-006 startOfFrame  input  1  one-cycle pulse marking the frame boundary.
REQ-007 drawingRequestBalls  input  NUM_BALLS  per-ball drawing request for the current pixel.
REQ-008 drawingRequestHoles  input  NUM_HOLES  per-hole drawing request for the current pixel.
REQ-009 pocketReady  input  1  consumer accepts the offered pocket event.
REQ-010 clearSunk  input  1  one-cycle pulse that clears all sunk, pending and counter state (new rack).
REQ-011 pocketValid  output  1  a pocket event is offered.
REQ-012 pocketBall  output  4  index of the offered ball.
REQ-013 pocketHole  output  3  index of the hole that ball fell into.
REQ-014 sunkMask  output  NUM_BALLS  registered mask of balls already reported.

Function
REQ-015 Overlap pixel: a cycle in which drawingRequestBalls[b]=1, sunkMask[b]=0 and any drawingRequestHoles bit=1.
REQ-016 Each ball has a 7-bit overlap counter, incremented on each overlap pixel, saturating at 127.
REQ-017 On the first overlap pixel of ball b in a frame, the lowest asserted hole index is latched as holeIdx[b]; later overlaps that frame do not change it.
REQ-018 On startOfFrame: pending[b] is set for every ball with counter >= OVERLAP_THRESH and sunkMask[b]=0; all counters clear and holeIdx latching re-arms, in that same cycle.
REQ-019 Pixel-level overlap in the startOfFrame cycle counts toward the new frame (counter loads 1 if overlapping, else 0).
REQ-020 FSM states: IDLE (no pending), OFFER (pocketValid=1), ACK (one cycle, updates masks); transitions IDLE->OFFER when pending non-zero, OFFER->ACK when pocketReady=1, ACK->OFFER if pending still non-zero else IDLE.
REQ-021 In OFFER, pocketBall is the lowest-index pending ball and pocketHole its holeIdx; both are registered and stable until accepted.
REQ-022 Handshake completes in a cycle with pocketValid=1 and pocketReady=1; pocketValid drops in the following (ACK) cycle.
REQ-023 In ACK, the accepted ball's pending bit clears and its sunkMask bit sets.
REQ-024 Pending bits set by startOfFrame during OFFER or ACK are OR-ed in; the offered event does not change before acceptance.
REQ-025 A sunk ball never increments its counter and is never re-offered until clearSunk.
REQ-026 clearSunk clears counters, pending, sunkMask and returns the FSM to IDLE next cycle; it overrides startOfFrame and an in-flight handshake in the same cycle (that event is dropped).
REQ-027 Minimum spacing between consecutive accepted events is 2 cycles (OFFER, ACK).

Reset
REQ-028 While resetN=0: pocketValid=0, pocketBall=0, pocketHole=0, sunkMask=0, all counters, pending and holeIdx=0, FSM=IDLE.
REQ-029 After resetN deasserts, no event is offered before the second startOfFrame pulse.

Verification
REQ-030 Ball 3 overlaps hole 2 for 64 pixels in frame, then startOfFrame, with pocketReady=1 -> pocketValid=1 one cycle later, pocketBall=3, pocketHole=2, then sunkMask=0x0008.
REQ-031 Ball 3 overlaps for 63 pixels then startOfFrame -> pocketValid stays 0; the counter restarts from 0 next frame.
REQ-032 Balls 5 and 1 both exceed threshold with pocketReady held 0 for 10 cycles -> pocketBall=1 stable for all 10 cycles; after ready, ball 5 is offered 2 cycles after the first acceptance.
REQ-033 Ball 0 overlaps holes 4 and 1 simultaneously on its first overlap pixel -> pocketHole=1.
REQ-034 Sunk ball 3 overlaps for 200 pixels -> no event; clearSunk then 64 overlap pixels and startOfFrame -> ball 3 offered again.
REQ-035 resetN pulsed low during OFFER -> pocketValid=0 immediately (asynchronous) and sunkMask=0.

Source files
------------

// File: rtl/pocket_controller.sv
`default_nettype none
// ============================================================================
// Module  : pocket_controller
// Brief   : Detects balls overlapping holes per frame and offers pocket events.
// Revision: 1.0
// ============================================================================
module pocket_controller #(
    parameter int NUM_BALLS      = 16,
    parameter int NUM_HOLES      = 6,
    parameter int OVERLAP_THRESH = 64
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic                 startOfFrame,
    input  logic [NUM_BALLS-1:0] drawingRequestBalls,
    input  logic [NUM_HOLES-1:0] drawingRequestHoles,
    input  logic                 pocketReady,
    input  logic                 clearSunk,
    output logic                 pocketValid,
    output logic [3:0]           pocketBall,
    output logic [2:0]           pocketHole,
    output logic [NUM_BALLS-1:0] sunkMask
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] OFFER = 2'd1;
    localparam logic [1:0] ACK   = 2'd2;

    localparam logic [6:0] CNT_MAX = 7'd127;
    localparam logic [6:0] THRESH  = 7'(OVERLAP_THRESH);

    logic [6:0]           cnt_q    [NUM_BALLS];
    logic [6:0]           cnt_d    [NUM_BALLS];
    logic [2:0]           hole_q   [NUM_BALLS];
    logic [2:0]           hole_d   [NUM_BALLS];
    logic [2:0]           phole_q  [NUM_BALLS];
    logic [2:0]           phole_d  [NUM_BALLS];
    logic [NUM_BALLS-1:0] pending_q, pending_d;
    logic [NUM_BALLS-1:0] sunk_q, sunk_d;
    logic [1:0]           state_q, state_d;
    logic [3:0]           ball_q, ball_d;
    logic [2:0]           out_hole_q, out_hole_d;
    logic                 armed_q, armed_d;

    logic                 w_hole_any;
    logic [2:0]           w_hole_low;
    logic [NUM_BALLS-1:0] w_overlap;
    logic [NUM_BALLS-1:0] w_new_pend;
    logic [NUM_BALLS-1:0] w_ack_mask;
    logic [NUM_BALLS-1:0] w_pend_next;
    logic [2:0]           w_hole_sel [NUM_BALLS];
    logic [3:0]           w_next_ball;
    logic [2:0]           w_next_hole;

    always_comb begin
        w_hole_any = |drawingRequestHoles;
        w_hole_low = 3'd0;
        for (int h = NUM_HOLES - 1; h >= 0; h--) begin
            if (drawingRequestHoles[h]) w_hole_low = 3'(h);
        end
    end

    // A zero counter means the ball has not overlapped yet this frame, so it
    // doubles as the hole-latch arm flag (the counter saturates, never wraps).
    always_comb begin
        for (int b = 0; b < NUM_BALLS; b++) begin
            w_overlap[b]  = drawingRequestBalls[b] & ~sunk_q[b] & w_hole_any;
            w_new_pend[b] = startOfFrame & armed_q & ~sunk_q[b] & (cnt_q[b] >= THRESH);
            w_hole_sel[b] = w_new_pend[b] ? hole_q[b] : phole_q[b];
            w_ack_mask[b] = (state_q == ACK) && (ball_q == 4'(b));

            cnt_d[b] = cnt_q[b];
            if (startOfFrame) begin
                cnt_d[b] = {6'd0, w_overlap[b]};
            end else if (w_overlap[b] && (cnt_q[b] != CNT_MAX)) begin
                cnt_d[b] = cnt_q[b] + 7'd1;
            end
            if (clearSunk) cnt_d[b] = 7'd0;

            hole_d[b] = hole_q[b];
            if (w_overlap[b] && (startOfFrame || (cnt_q[b] == 7'd0))) begin
                hole_d[b] = w_hole_low;
            end
            phole_d[b] = w_hole_sel[b];
        end
    end

    always_comb begin
        w_pend_next = (pending_q | w_new_pend) & ~w_ack_mask;
        w_next_ball = 4'd0;
        w_next_hole = 3'd0;
        for (int b = NUM_BALLS - 1; b >= 0; b--) begin
            if (w_pend_next[b]) begin
                w_next_ball = 4'(b);
                w_next_hole = w_hole_sel[b];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ball_d     = ball_q;
        out_hole_d = out_hole_q;
        pending_d  = w_pend_next;
        sunk_d     = sunk_q | w_ack_mask;
        armed_d    = armed_q | startOfFrame;

        case (state_q)
            IDLE: begin
                if (|w_pend_next) begin
                    state_d    = OFFER;
                    ball_d     = w_next_ball;
                    out_hole_d = w_next_hole;
                end
            end
            OFFER: begin
                if (pocketReady) state_d = ACK;
            end
            ACK: begin
                if (|w_pend_next) begin
                    state_d    = OFFER;
                    ball_d     = w_next_ball;
                    out_hole_d = w_next_hole;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // New rack wins over everything, including a handshake in progress.
        if (clearSunk) begin
            state_d    = IDLE;
            ball_d     = 4'd0;
            out_hole_d = 3'd0;
            pending_d  = '0;
            sunk_d     = '0;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int b = 0; b < NUM_BALLS; b++) begin
                cnt_q[b]   <= 7'd0;
                hole_q[b]  <= 3'd0;
                phole_q[b] <= 3'd0;
            end
            pending_q  <= '0;
            sunk_q     <= '0;
            state_q    <= IDLE;
            ball_q     <= 4'd0;
            out_hole_q <= 3'd0;
            armed_q    <= 1'b0;
        end else begin
            for (int b = 0; b < NUM_BALLS; b++) begin
                cnt_q[b]   <= cnt_d[b];
                hole_q[b]  <= hole_d[b];
                phole_q[b] <= phole_d[b];
            end
            pending_q  <= pending_d;
            sunk_q     <= sunk_d;
            state_q    <= state_d;
            ball_q     <= ball_d;
            out_hole_q <= out_hole_d;
            armed_q    <= armed_d;
        end
    end

    assign pocketValid = (state_q == OFFER);
    assign pocketBall  = ball_q;
    assign pocketHole  = out_hole_q;
    assign sunkMask    = sunk_q;

endmodule
`default_nettype wire

// File: tb/tb_pocket_controller.sv
`default_nettype none
// ============================================================================
// Module  : tb_pocket_controller
// Brief   : Directed self-checking bench for pocket_controller.
// Revision: 1.0
// ============================================================================
module tb_pocket_controller;

    logic        clk = 1'b0;
    logic        resetN;
    logic        startOfFrame;
    logic [15:0] drawingRequestBalls;
    logic [5:0]  drawingRequestHoles;
    logic        pocketReady;
    logic        clearSunk;
    logic        pocketValid;
    logic [3:0]  pocketBall;
    logic [2:0]  pocketHole;
    logic [15:0] sunkMask;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pocket_controller #(
        .NUM_BALLS      (16),
        .NUM_HOLES      (6),
        .OVERLAP_THRESH (64)
    ) dut (
        .clk                 (clk),
        .resetN              (resetN),
        .startOfFrame        (startOfFrame),
        .drawingRequestBalls (drawingRequestBalls),
        .drawingRequestHoles (drawingRequestHoles),
        .pocketReady         (pocketReady),
        .clearSunk           (clearSunk),
        .pocketValid         (pocketValid),
        .pocketBall          (pocketBall),
        .pocketHole          (pocketHole),
        .sunkMask            (sunkMask)
    );

    // Stimulus helpers start and end just after a falling edge.
    task automatic drive_overlap(input int ball, input logic [5:0] holes, input int n);
        for (int i = 0; i < n; i++) begin
            drawingRequestBalls = 16'(1) << ball;
            drawingRequestHoles = holes;
            @(negedge clk);
        end
        drawingRequestBalls = '0;
        drawingRequestHoles = '0;
    endtask

    task automatic pulse_sof();
        startOfFrame = 1'b1;
        @(negedge clk);
        startOfFrame = 1'b0;
    endtask

    task automatic test_reset();
        resetN = 1'b0; startOfFrame = 1'b0; drawingRequestBalls = '0;
        drawingRequestHoles = '0; pocketReady = 1'b0; clearSunk = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (pocketValid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0h want 0", pocketValid); end
        checks++; if (pocketBall !== 4'd0) begin errors++; $display("FAIL reset_ball: got %0h want 0", pocketBall); end
        checks++; if (pocketHole !== 3'd0) begin errors++; $display("FAIL reset_hole: got %0h want 0", pocketHole); end
        checks++; if (sunkMask !== 16'h0) begin errors++; $display("FAIL reset_sunk: got %0h want 0", sunkMask); end
        resetN = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_first_frame();
        drive_overlap(2, 6'b000001, 70);
        pulse_sof();
        checks++; if (pocketValid !== 1'b0) begin errors++; $display("FAIL first_sof_no_event: got %0h want 0", pocketValid); end
        @(negedge clk);
        checks++; if (pocketValid !== 1'b0) begin errors++; $display("FAIL first_sof_no_event_late: got %0h want 0", pocketValid); end
        pulse_sof();
        checks++; if (pocketValid !== 1'b0) begin errors++; $display("FAIL second_sof_empty: got %0h want 0", pocketValid); end
    endtask

    task automatic test_below_thresh();
        drive_overlap(3, 6'b000100, 63);
        pulse_sof();
        checks++; if (pocketValid !== 1'b0) begin errors++; $display("FAIL below_thresh: got %0h want 0", pocketValid); end
        @(negedge clk);
        checks++; if (pocketValid !== 1'b0) begin errors++; $display("FAIL below_thresh_late: got %0h want 0", pocketValid); end
        drive_overlap(3, 6'b000100, 63);
        pulse_sof();
        checks++; if (pocketValid !== 1'b0) begin errors++; $display("FAIL counter_restart: got %0h want 0", pocketValid); end
    endtask

    task automatic test_pocket_basic();
        pocketReady = 1'b1;
        drive_overlap(3, 6'b000100, 64);
        pulse_sof();
        checks++; if (pocketValid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %0h want 1", pocketValid); end
        checks++; if (pocketBall !== 4'd3) begin errors++; $display("FAIL basic_ball: got %0h want 3", pocketBall); end
        checks++; if (pocketHole !== 3'd2) begin errors++; $display("FAIL basic_hole: got %0h want 2", pocketHole); end
        @(negedge clk);
        checks++; if (pocketValid !== 1'b0) begin errors++; $display("FAIL basic_ack_valid: got %0h want 0", pocketValid); end
        checks++; if (sunkMask !== 16'h0000) begin errors++; $display("FAIL basic_ack_sunk: got %0h want 0", sunkMask); end
        @(negedge clk);
        checks++; if (sunkMask !== 16'h0008) begin errors++; $display("FAIL basic_sunk: got %0h want 0008", sunkMask); end
        checks++; if (pocketValid !== 1'b0) begin errors++; $display("FAIL basic_idle: got %0h want 0", pocketValid); end
        pocketReady = 1'b0;
    endtask

    task automatic test_hold_and_order();
        pocketReady = 1'b0;
        drive_overlap(5, 6'b001000, 64);
        drive_overlap(1, 6'b000001, 64);
        pulse_sof();
        checks++; if ({pocketValid, pocketBall, pocketHole} !== {1'b1, 4'd1, 3'd0}) begin
            errors++; $display("FAIL hold_first: got v%0h b%0h h%0h want v1 b1 h0", pocketValid, pocketBall, pocketHole); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++; if ({pocketValid, pocketBall, pocketHole} !== {1'b1, 4'd1, 3'd0}) begin
                errors++; $display("FAIL hold_stable[%0d]: got v%0h b%0h h%0h want v1 b1 h0", i, pocketValid, pocketBall, pocketHole); end
        end
        pocketReady = 1'b1;
        @(negedge clk);
        checks++; if (pocketValid !== 1'b0) begin errors++; $display("FAIL hold_ack: got %0h want 0", pocketValid); end
        @(negedge clk);
        checks++; if ({pocketValid, pocketBall, pocketHole} !== {1'b1, 4'd5, 3'd3}) begin
            errors++; $display("FAIL second_offer: got v%0h b%0h h%0h want v1 b5 h3", pocketValid, pocketBall, pocketHole); end
        checks++; if (sunkMask !== 16'h000A) begin errors++; $display("FAIL hold_sunk1: got %0h want 000a", sunkMask); end
        @(negedge clk);
        checks++; if (pocketValid !== 1'b0) begin errors++; $display("FAIL second_ack: got %0h want 0", pocketValid); end
        @(negedge clk);
        checks++; if (sunkMask !== 16'h002A) begin errors++; $display("FAIL hold_sunk2: got %0h want 002a", sunkMask); end
        pocketReady = 1'b0;
    endtask

    task automatic test_hole_priority();
        pocketReady = 1'b0;
        drawingRequestBalls = 16'h0001;
        drawingRequestHoles = 6'b010010;
        @(negedge clk);
        drive_overlap(0, 6'b010000, 63);
        pulse_sof();
        checks++; if ({pocketValid, pocketBall, pocketHole} !== {1'b1, 4'd0, 3'd1}) begin
            errors++; $display("FAIL hole_priority: got v%0h b%0h h%0h want v1 b0 h1", pocketValid, pocketBall, pocketHole); end
        pocketReady = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (sunkMask !== 16'h002B) begin errors++; $display("FAIL hole_priority_sunk: got %0h want 002b", sunkMask); end
        pocketReady = 1'b0;
    endtask

    task automatic test_sunk_ball();
        drive_overlap(3, 6'b000100, 200);
        pulse_sof();
        checks++; if (pocketValid !== 1'b0) begin errors++; $display("FAIL sunk_no_event: got %0h want 0", pocketValid); end
        @(negedge clk);
        checks++; if (pocketValid !== 1'b0) begin errors++; $display("FAIL sunk_no_event_late: got %0h want 0", pocketValid); end
        clearSunk = 1'b1;
        @(negedge clk);
        clearSunk = 1'b0;
        checks++; if (sunkMask !== 16'h0) begin errors++; $display("FAIL clear_sunk: got %0h want 0", sunkMask); end
        drive_overlap(3, 6'b000100, 64);
        pulse_sof();
        checks++; if ({pocketValid, pocketBall, pocketHole} !== {1'b1, 4'd3, 3'd2}) begin
            errors++; $display("FAIL reoffer: got v%0h b%0h h%0h want v1 b3 h2", pocketValid, pocketBall, pocketHole); end
    endtask

    task automatic test_clear_override();
        clearSunk = 1'b1;
        pocketReady = 1'b1;
        @(negedge clk);
        clearSunk = 1'b0;
        pocketReady = 1'b0;
        checks++; if ({pocketValid, sunkMask} !== 17'h0) begin
            errors++; $display("FAIL clear_override: got v%0h s%0h want v0 s0", pocketValid, sunkMask); end
        @(negedge clk);
        checks++; if ({pocketValid, sunkMask} !== 17'h0) begin
            errors++; $display("FAIL clear_drop: got v%0h s%0h want v0 s0", pocketValid, sunkMask); end
    endtask

    task automatic test_async_reset();
        pocketReady = 1'b0;
        drive_overlap(6, 6'b100000, 64);
        drive_overlap(9, 6'b000010, 64);
        pulse_sof();
        checks++; if ({pocketValid, pocketBall, pocketHole} !== {1'b1, 4'd6, 3'd5}) begin
            errors++; $display("FAIL pre_reset_offer: got v%0h b%0h h%0h want v1 b6 h5", pocketValid, pocketBall, pocketHole); end
        pocketReady = 1'b1;
        @(negedge clk);
        pocketReady = 1'b0;
        @(negedge clk);
        checks++; if ({pocketValid, pocketBall, pocketHole} !== {1'b1, 4'd9, 3'd1}) begin
            errors++; $display("FAIL pre_reset_offer2: got v%0h b%0h h%0h want v1 b9 h1", pocketValid, pocketBall, pocketHole); end
        checks++; if (sunkMask !== 16'h0040) begin errors++; $display("FAIL pre_reset_sunk: got %0h want 0040", sunkMask); end
        #2 resetN = 1'b0;
        #1;
        checks++; if (pocketValid !== 1'b0) begin errors++; $display("FAIL async_valid: got %0h want 0", pocketValid); end
        checks++; if (sunkMask !== 16'h0) begin errors++; $display("FAIL async_sunk: got %0h want 0", sunkMask); end
        checks++; if ({pocketBall, pocketHole} !== 7'h0) begin
            errors++; $display("FAIL async_outputs: got b%0h h%0h want b0 h0", pocketBall, pocketHole); end
        @(negedge clk);
        resetN = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_first_frame();
        test_below_thresh();
        test_pocket_basic();
        test_hold_and_order();
        test_hole_priority();
        test_sunk_ball();
        test_clear_override();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
